// File: rtl/timer_host_sequencer_pkg.sv
// Shared definitions for the interval-timer host sequencer: op codes, timer
// register map, control-word bit positions and the sequencer state encoding.
package timer_host_pkg;

    localparam logic [2:0] OP_SET_PERIOD = 3'd0;
    localparam logic [2:0] OP_START      = 3'd1;
    localparam logic [2:0] OP_STOP       = 3'd2;
    localparam logic [2:0] OP_SNAPSHOT   = 3'd3;
    localparam logic [2:0] OP_STATUS     = 3'd4;
    localparam logic [2:0] OP_CLEAR      = 3'd5;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WR_ST,
        ST_WR_SNAP,
        ST_RD_SL,
        ST_RD_SH,
        ST_RD_ST,
        ST_RD_CAP,
        ST_RESP,
        ST_IRQ_CLR
    } state_e;

    // mode = {continuous, irq_enable}; exactly one of START/STOP is set.
    function automatic logic [15:0] ctrl_word(input logic stop, input logic [1:0] mode);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = mode[0];
        w[CTRL_CONT]  = mode[1];
        w[CTRL_START] = ~stop;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_host_sequencer.sv
// Avalon-MM initiator that turns single local commands into interval-timer
// bus beats, returns one response per command and optionally services irq.
module timer_host_sequencer
    import timer_host_pkg::*;
#(
    parameter bit          IRQ_AUTO_CLEAR = 1'b1,
    parameter int unsigned IRQ_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [31:0]          cmd_data,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    input  logic                 irq,
    output logic [IRQ_CNT_W-1:0] irq_count,
    output logic [2:0]           address,
    output logic                 chipselect,
    output logic                 write_n,
    output logic [15:0]          writedata,
    input  logic [15:0]          readdata
);

    state_e state_q, state_d;

    logic [2:0]           op_q;
    logic [15:0]          hi_q;
    logic [15:0]          lo_q;
    logic                 irq_q;
    logic [IRQ_CNT_W-1:0] irq_cnt_q;

    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wd_q, wd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic irq_due;
    logic accept;
    logic cnt_inc;

    assign irq_due   = IRQ_AUTO_CLEAR && irq;
    assign cmd_ready = (state_q == ST_IDLE) && !irq_due;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_due) begin
                    state_d = ST_IRQ_CLR;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_SET_PERIOD:     state_d = ST_WR_PL;
                        OP_START, OP_STOP: state_d = ST_WR_CTRL;
                        OP_SNAPSHOT:       state_d = ST_WR_SNAP;
                        OP_STATUS:         state_d = ST_RD_ST;
                        OP_CLEAR:          state_d = ST_WR_ST;
                        default:           state_d = ST_RESP;
                    endcase
                end
            end
            ST_WR_PL:                state_d = ST_WR_PH;
            ST_WR_PH:                state_d = ST_RESP;
            ST_WR_CTRL, ST_WR_ST:    state_d = ST_RESP;
            ST_WR_SNAP:              state_d = ST_RD_SL;
            ST_RD_SL:                state_d = ST_RD_SH;
            ST_RD_SH, ST_RD_ST:      state_d = ST_RD_CAP;
            ST_RD_CAP:               state_d = ST_RESP;
            ST_RESP, ST_IRQ_CLR:     state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    // Beats entered straight from IDLE take the command fields unlatched.
    always_comb begin
        cs_d        = 1'b0;
        wn_d        = 1'b1;
        addr_d      = REG_STATUS;
        wd_d        = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        unique case (state_d)
            ST_WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = REG_PERIOD_L; wd_d = cmd_data[15:0];
            end
            ST_WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = REG_PERIOD_H; wd_d = hi_q;
            end
            ST_WR_CTRL: begin
                cs_d   = 1'b1; wn_d = 1'b0; addr_d = REG_CONTROL;
                wd_d   = ctrl_word(cmd_op == OP_STOP, cmd_data[1:0]);
            end
            ST_WR_ST, ST_IRQ_CLR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = REG_STATUS;
            end
            ST_WR_SNAP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = REG_SNAP_L;
            end
            ST_RD_SL: begin
                cs_d = 1'b1; addr_d = REG_SNAP_L;
            end
            ST_RD_SH: begin
                cs_d = 1'b1; addr_d = REG_SNAP_H;
            end
            ST_RD_ST: begin
                cs_d = 1'b1; addr_d = REG_STATUS;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = (state_q == ST_IDLE);
                rsp_data_d  = '0;
                if (state_q == ST_RD_CAP) begin
                    rsp_data_d = (op_q == OP_SNAPSHOT) ? {readdata, lo_q}
                                                       : {30'b0, readdata[1:0]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (IRQ_AUTO_CLEAR) begin
            cnt_inc = (state_q == ST_IDLE) && irq_due;
        end else begin
            cnt_inc = irq && !irq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            irq_cnt_q   <= '0;
            irq_q       <= 1'b0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            irq_q       <= irq;
            if (cnt_inc) begin
                irq_cnt_q <= irq_cnt_q + IRQ_CNT_W'(1);
            end
            if (accept) begin
                op_q <= cmd_op;
                hi_q <= cmd_data[31:16];
            end
            if (state_q == ST_RD_SH) begin
                lo_q <= readdata;
            end
        end
    end

    assign chipselect = cs_q;
    assign write_n    = wn_q;
    assign address    = addr_q;
    assign writedata  = wd_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign irq_count  = irq_cnt_q;

endmodule
